// File: rtl/syn_mod3_pkg.sv
// Shared types and helpers for the modulo-3 reducer: residue type and
// the base-4 digit to residue leaf map.
package syn_mod3_pkg;

    localparam int RES_W = 2;

    typedef logic [RES_W-1:0] residue_t;

    // A base-4 digit is its own residue except 3, which folds to 0.
    function automatic residue_t digit_to_residue(input logic [1:0] digit);
        residue_t res;
        case (digit)
            2'd1:    res = 2'd1;
            2'd2:    res = 2'd2;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/syn_mod3_if.sv
// Operand/result bundle for syn_mod3: the driver owns the operand,
// the reducer owns the residue.
interface syn_mod3_if
    import syn_mod3_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in;
    residue_t         out;

    modport master (output in, input out);
    modport slave  (input in, output out);
endinterface

// File: rtl/syn_mod3_add2.sv
// Mod-3 adder for two residues in {0,1,2}; the result is never 3.
module mod3_add2
    import syn_mod3_pkg::*;
(
    input  residue_t a,
    input  residue_t b,
    output residue_t sum
);
    logic [2:0] raw_s;

    assign raw_s = {1'b0, a} + {1'b0, b};

    // Fold the 0..4 raw sum back into a residue.
    always_comb begin
        sum = raw_s[1:0];
        if (raw_s >= 3'd3) begin
            sum = 2'(raw_s - 3'd3);
        end else begin
            sum = raw_s[1:0];
        end
    end
endmodule

// File: rtl/syn_mod3.sv
// Divider-free in % 3: sums base-4 digit residues through a balanced tree
// of mod-3 adders, with an optional single output register stage.
module syn_mod3
    import syn_mod3_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit REGISTERED = 1'b0
)(
    input  logic      clk,
    input  logic      reset,
    syn_mod3_if.slave bus
);
    localparam int EW     = WIDTH + (WIDTH % 2);
    localparam int NDIG   = EW / 2;
    localparam int NNODES = 2 * NDIG - 1;

    logic [EW-1:0] ext_s;
    residue_t      node_s [NNODES];

    assign ext_s = EW'(bus.in);

    // Heap-ordered tree: node i sums nodes 2i+1 and 2i+2, leaves occupy the
    // last NDIG slots, so the root lands at node 0 after ceil(log2(NDIG)) levels.
    for (genvar d = 0; d < NDIG; d++) begin : g_leaf
        assign node_s[NDIG - 1 + d] = digit_to_residue(ext_s[2*d +: 2]);
    end

    for (genvar i = 0; i < NDIG - 1; i++) begin : g_node
        mod3_add2 u_add (
            .a   (node_s[2*i + 1]),
            .b   (node_s[2*i + 2]),
            .sum (node_s[i])
        );
    end

    if (REGISTERED) begin : g_reg
        residue_t out_r;

        // Output stage: reset wins over the freshly computed residue.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_r <= 2'd0;
            end else begin
                out_r <= node_s[0];
            end
        end

        assign bus.out = out_r;
    end else begin : g_comb
        logic unused_clk_rst_s;

        assign unused_clk_rst_s = clk ^ reset;
        assign bus.out          = node_s[0];
    end
endmodule

// File: tb/tb_syn_mod3.sv
// Self-checking bench for syn_mod3 over several WIDTH/REGISTERED builds,
// using a vector table plus a scoreboard queue of expected residues.
module tb_syn_mod3;
    logic clk;
    logic reset;

    syn_mod3_if #(.WIDTH(8))  if8c ();
    syn_mod3_if #(.WIDTH(32)) if32c ();
    syn_mod3_if #(.WIDTH(7))  if7c ();
    syn_mod3_if #(.WIDTH(1))  if1c ();
    syn_mod3_if #(.WIDTH(2))  if2c ();
    syn_mod3_if #(.WIDTH(8))  if8r ();

    syn_mod3 #(.WIDTH(8),  .REGISTERED(1'b0)) u8c  (.clk(clk), .reset(reset), .bus(if8c.slave));
    syn_mod3 #(.WIDTH(32), .REGISTERED(1'b0)) u32c (.clk(clk), .reset(reset), .bus(if32c.slave));
    syn_mod3 #(.WIDTH(7),  .REGISTERED(1'b0)) u7c  (.clk(clk), .reset(reset), .bus(if7c.slave));
    syn_mod3 #(.WIDTH(1),  .REGISTERED(1'b0)) u1c  (.clk(clk), .reset(reset), .bus(if1c.slave));
    syn_mod3 #(.WIDTH(2),  .REGISTERED(1'b0)) u2c  (.clk(clk), .reset(reset), .bus(if2c.slave));
    syn_mod3 #(.WIDTH(8),  .REGISTERED(1'b1)) u8r  (.clk(clk), .reset(reset), .bus(if8r.slave));

    localparam int C8 = 0, C32 = 1, C7 = 2, C1 = 3, C2 = 4, C8R = 5;

    typedef struct {
        int          cfg;
        logic [31:0] val;
        logic [1:0]  exp;
        string       name;
    } vec_t;

    vec_t       tbl [$];
    logic [1:0] sb  [$];
    int         n_vec;
    int         n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int cfg, input logic [31:0] v);
        case (cfg)
            C8:      if8c.in  = v[7:0];
            C32:     if32c.in = v;
            C7:      if7c.in  = v[6:0];
            C1:      if1c.in  = v[0];
            C2:      if2c.in  = v[1:0];
            default: if8r.in  = v[7:0];
        endcase
    endtask

    function automatic logic [1:0] read_out(input int cfg);
        case (cfg)
            C8:      return if8c.out;
            C32:     return if32c.out;
            C7:      return if7c.out;
            C1:      return if1c.out;
            C2:      return if2c.out;
            default: return if8r.out;
        endcase
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [31:0] stim);
        logic [1:0] exp;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: got %0d with no expected value queued (in=%0h)", name, act, stim);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s: got %0d, want %0d (in=%0h)", name, act, exp, stim);
            end
        end
    endtask

    // Combinational builds: drive, queue expectation, settle, compare.
    task automatic comb_vec(input int cfg, input logic [31:0] v, input logic [1:0] exp, input string name);
        drive(cfg, v);
        sb.push_back(exp);
        #1;
        check(name, read_out(cfg), v);
    endtask

    // Registered build: compare just after the next rising edge.
    task automatic reg_edge(input logic [1:0] exp, input string name);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        check(name, if8r.out, {24'd0, if8r.in});
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        if8c.in  = 8'd0;
        if32c.in = 32'd0;
        if7c.in  = 7'd0;
        if1c.in  = 1'b0;
        if2c.in  = 2'd0;
        if8r.in  = 8'd5;

        tbl.push_back('{C8,  32'd0,          2'd0, "w8_zero"});
        tbl.push_back('{C8,  32'd100,        2'd1, "w8_100"});
        tbl.push_back('{C8,  32'd254,        2'd2, "w8_254"});
        tbl.push_back('{C8,  32'd255,        2'd0, "w8_255"});
        tbl.push_back('{C32, 32'hFFFF_FFFF,  2'd0, "w32_ones"});
        tbl.push_back('{C32, 32'h8000_0000,  2'd2, "w32_msb"});
        tbl.push_back('{C32, 32'h5555_5555,  2'd1, "w32_5555"});
        tbl.push_back('{C32, 32'h7FFF_FFFF,  2'd1, "w32_7fff"});
        tbl.push_back('{C32, 32'd0,          2'd0, "w32_zero"});
        tbl.push_back('{C7,  32'd127,        2'd1, "w7_127"});
        tbl.push_back('{C7,  32'd126,        2'd0, "w7_126"});
        tbl.push_back('{C1,  32'd1,          2'd1, "w1_one"});
        tbl.push_back('{C1,  32'd0,          2'd0, "w1_zero"});
        tbl.push_back('{C2,  32'd3,          2'd0, "w2_three"});
        tbl.push_back('{C2,  32'd2,          2'd2, "w2_two"});

        foreach (tbl[i]) begin
            comb_vec(tbl[i].cfg, tbl[i].val, tbl[i].exp, tbl[i].name);
        end

        for (int i = 0; i < 256; i++) begin
            v = 32'(i);
            comb_vec(C8, v, 2'(v % 32'd3), "w8_sweep");
        end
        for (int i = 0; i < 128; i++) begin
            v = 32'(i);
            comb_vec(C7, v, 2'(v % 32'd3), "w7_sweep");
        end
        for (int i = 0; i < 2; i++) begin
            v = 32'(i);
            comb_vec(C1, v, 2'(v % 32'd3), "w1_sweep");
        end
        for (int i = 0; i < 4; i++) begin
            v = 32'(i);
            comb_vec(C2, v, 2'(v % 32'd3), "w2_sweep");
        end
        for (int i = 0; i < 10000; i++) begin
            v = $urandom();
            comb_vec(C32, v, 2'(v % 32'd3), "w32_rand");
        end

        // Registered build: reset held two edges with in=5.
        @(negedge clk);
        reset   = 1'b1;
        if8r.in = 8'd5;
        reg_edge(2'd0, "reg_rst_hold0");
        reg_edge(2'd0, "reg_rst_hold1");
        @(negedge clk);
        reset = 1'b0;
        reg_edge(2'd2, "reg_first_after_rst");
        @(negedge clk);
        if8r.in = 8'd7;
        sb.push_back(2'd2);
        #1;
        check("reg_no_bypass", if8r.out, 32'd7);
        reg_edge(2'd1, "reg_one_cycle");

        // Reset landing mid-stream discards the in-flight residue.
        @(negedge clk);
        if8r.in = 8'd254;
        reg_edge(2'd2, "reg_stream0");
        reg_edge(2'd2, "reg_stream1");
        @(negedge clk);
        reset = 1'b1;
        reg_edge(2'd0, "reg_mid_rst");
        @(negedge clk);
        reset = 1'b0;
        reg_edge(2'd2, "reg_resume");

        // Registered stream of varied operands, one per edge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v = 32'($urandom_range(255, 0));
            if8r.in = v[7:0];
            reg_edge(2'(v % 32'd3), "reg_stream_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
